// File: rtl/addr_counter.sv
// Rollover address counter with packet-level rollback.
// Generates buffer addresses 1..rollover_val. It snapshots the address at each packet start,
// and a packet error restores that snapshot so the bad packet's writes are discarded.
module addr_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    start,
  input  logic                    error,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
  localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic [NUM_CNT_BITS-1:0] saved_q, saved_d;
  logic                    flag_q, flag_d;

  // Next-state decode: clear > error > count/hold; start snapshots the pre-increment value.
  always_comb begin
    count_d = count_q;
    saved_d = saved_q;
    if (clear) begin
      count_d = CntZero;
      saved_d = CntZero;
    end else if (error) begin
      // Rollback wins over both counting and a simultaneous start.
      count_d = saved_q;
    end else begin
      if (start) begin
        saved_d = count_q;
      end
      if (count_enable) begin
        // Above rollover_val there is no match, so the add wraps naturally at the top.
        count_d = (count_q == rollover_val) ? CntOne : count_q + CntOne;
      end
    end
    // The flag is registered from the next count, so it moves together with count_out.
    flag_d = clear ? 1'b0 : (count_d == rollover_val);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= CntZero;
      saved_q <= CntZero;
      flag_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      saved_q <= saved_d;
      flag_q  <= flag_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;

endmodule

// File: tb/tb_addr_counter.sv
// Scoreboard bench for addr_counter: a behavioural model pushes the expected {flag, count}
// each time stimulus is driven, and the result is popped and compared just after the edge.
module tb_addr_counter;
  localparam int W = 4;

  logic         tb_clk = 1'b0;
  logic         n_rst;
  logic         clear;
  logic         count_enable;
  logic         start;
  logic         error;
  logic [W-1:0] rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag;

  int checks = 0;
  int errors = 0;

  // Expected {flag, count} after each driven edge.
  logic [W:0]   exp_q[$];
  logic [W:0]   got;
  logic [W:0]   exp;
  logic [W-1:0] m_count;
  logic [W-1:0] m_saved;
  logic         m_flag;

  addr_counter #(.NUM_CNT_BITS(W)) dut (
    .clk          (tb_clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .start        (start),
    .error        (error),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  always #5 tb_clk = ~tb_clk;

  // Drive one cycle of inputs, advance the model, push the expectation, and wait past the edge.
  task automatic cycle(input logic c, input logic en, input logic st, input logic er,
                       input logic [W-1:0] rv);
    logic [W-1:0] nc;
    logic [W-1:0] ns;
    clear = c; count_enable = en; start = st; error = er; rollover_val = rv;
    nc = m_count;
    ns = m_saved;
    if (c) begin
      nc = '0;
      ns = '0;
    end else if (er) begin
      nc = m_saved;
    end else begin
      if (st) ns = m_count;
      if (en) nc = (m_count == rv) ? W'(1) : W'(m_count + 1);
    end
    m_count = nc;
    m_saved = ns;
    m_flag  = c ? 1'b0 : (nc == rv);
    exp_q.push_back({m_flag, m_count});
    @(posedge tb_clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    clear = 1'b0; count_enable = 1'b0; start = 1'b0; error = 1'b0;
    m_count = '0; m_saved = '0; m_flag = 1'b0;
    exp_q.delete();
    @(posedge tb_clk);
    @(negedge tb_clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    clear = 1'b0; start = 1'b0; error = 1'b0;
    count_enable = 1'b1; rollover_val = 4'd8;
    repeat (2) @(posedge tb_clk);
    #1;
    checks++;
    if ({rollover_flag, count_out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_en1: got flag=%b count=%0d, want 0/0", rollover_flag, count_out);
    end
    count_enable = 1'b0;
    @(posedge tb_clk);
    #1;
    checks++;
    if ({rollover_flag, count_out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_en0: got flag=%b count=%0d, want 0/0", rollover_flag, count_out);
    end
    m_count = '0; m_saved = '0; m_flag = 1'b0;
    exp_q.delete();
    @(negedge tb_clk);
    n_rst = 1'b1;
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd8);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp || got !== 5'b0_0000) begin
        errors++;
        $display("FAIL clear[%0d]: got %b want %b (and 0/0)", i, got, exp);
      end
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b1, (i == 1), 1'b0, 4'd8);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wrap8_edge%0d: got %b want %b", i, got, exp);
      end
      if (i == 4 || i == 8 || i == 9) begin
        checks++;
        if ((i == 4 && got !== 5'b0_0100) || (i == 8 && got !== 5'b1_1000) ||
            (i == 9 && got !== 5'b0_0001)) begin
          errors++;
          $display("FAIL wrap8_fixed_edge%0d: got %b", i, got);
        end
      end
    end
  endtask

  task automatic test_rv15();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rv15_edge%0d: got %b want %b", i, got, exp);
      end
      if (i == 15) begin
        checks++;
        if (got !== 5'b1_1111) begin
          errors++;
          $display("FAIL rv15_terminal: got %b want 11111", got);
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      // Enable on edges 1-3, off 4-5, on at 6 (reaches 4), off 7-8 (flag held at terminal).
      cycle(1'b0, (i <= 3 || i == 6), 1'b0, 1'b0, 4'd4);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold_edge%0d: got %b want %b", i, got, exp);
      end
      if (i == 5 || i == 8) begin
        checks++;
        if ((i == 5 && got !== 5'b0_0011) || (i == 8 && got !== 5'b1_0100)) begin
          errors++;
          $display("FAIL hold_fixed_edge%0d: got %b", i, got);
        end
      end
    end
  endtask

  task automatic test_rollback();
    logic st, er, cl;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      // 10: error -> 3; 11: error+start -> still 3; 12-13 count; 14: error -> 3;
      // 15: start+count; 16: error+clear -> 0.
      st = (i == 1 || i == 4 || i == 11 || i == 15);
      er = (i == 10 || i == 11 || i == 14 || i == 16);
      cl = (i == 16);
      cycle(cl, 1'b1, st, er, 4'd12);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rollback_edge%0d: got %b want %b", i, got, exp);
      end
      if (i == 9 || i == 10 || i == 11 || i == 14 || i == 16) begin
        checks++;
        if ((i == 9 && got !== 5'b0_1001) || (i == 10 && got !== 5'b0_0011) ||
            (i == 11 && got !== 5'b0_0011) || (i == 14 && got !== 5'b0_0011) ||
            (i == 16 && got !== 5'b0_0000)) begin
          errors++;
          $display("FAIL rollback_fixed_edge%0d: got %b", i, got);
        end
      end
    end
  endtask

  task automatic test_rv_edge_cases();
    do_reset();
    // rollover_val = 0: 1..15 then 0 with flag high at 0.
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rv0_edge%0d: got %b want %b", i, got, exp);
      end
      if (i == 16) begin
        checks++;
        if (got !== 5'b1_0000) begin
          errors++;
          $display("FAIL rv0_wrap: got %b want 10000", got);
        end
      end
    end
    // Count to 10, then drop rollover_val below the count: wraps through 15 -> 0.
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, (i <= 10) ? 4'd15 : 4'd5);
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rv_below_edge%0d: got %b want %b", i, got, exp);
      end
      if (i == 16) begin
        checks++;
        if (got !== 5'b0_0000) begin
          errors++;
          $display("FAIL rv_below_wrap: got %b want 00000", got);
        end
      end
    end
  endtask

  task automatic test_async_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, (i == 3), 1'b0, 4'd12);
    exp_q.delete();
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({rollover_flag, count_out} !== 5'b0_0000) begin
      errors++;
      $display("FAIL async_reset: got flag=%b count=%0d, want 0/0", rollover_flag, count_out);
    end
    m_count = '0; m_saved = '0; m_flag = 1'b0;
    @(negedge tb_clk);
    n_rst = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    for (int i = 0; i < 2; i++) begin
      got = {rollover_flag, count_out};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp && i == 1) begin
        errors++;
        $display("FAIL reset_then_error: got %b want %b", got, exp);
      end
    end
    checks++;
    if (got !== 5'b0_0000) begin
      errors++;
      $display("FAIL reset_then_error_fixed: got %b want 00000", got);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            (i % 40 < 30) ? W'($urandom_range(5, 15)) : W'($urandom_range(0, 15)));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL random_queue_empty at %0d", i);
      end else begin
        got = {rollover_flag, count_out};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_%0d: got %b want %b", i, got, exp);
        end
      end
    end
  endtask

  initial begin
    m_count = '0; m_saved = '0; m_flag = 1'b0;
    test_reset();
    test_clear();
    test_count_wrap();
    test_rv15();
    test_hold();
    test_rollback();
    test_rv_edge_cases();
    test_async_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
